// File: rtl/baudgen_frac_pkg.sv
// Shared constants for the fractional baud generator: x16 divisors for the
// standard rates at 100 MHz, plus the idle/run phase encoding.
package baudgen_frac_pkg;

  localparam int unsigned CLK_HZ = 100_000_000;

  // Integer part and 1/16 fraction of CLK_HZ / (16 * rate)
  localparam int unsigned B9600_INT    = 651;
  localparam int unsigned B9600_FRAC   = 1;
  localparam int unsigned B19200_INT   = 325;
  localparam int unsigned B19200_FRAC  = 8;
  localparam int unsigned B38400_INT   = 162;
  localparam int unsigned B38400_FRAC  = 12;
  localparam int unsigned B57600_INT   = 108;
  localparam int unsigned B57600_FRAC  = 8;
  localparam int unsigned B115200_INT  = 54;
  localparam int unsigned B115200_FRAC = 4;
  localparam int unsigned B230400_INT  = 27;
  localparam int unsigned B230400_FRAC = 2;

  typedef enum logic {
    PH_IDLE = 1'b0,
    PH_RUN  = 1'b1
  } phase_e;

  typedef struct packed {
    logic [15:0] div_int;
    logic [3:0]  div_frac;
  } baud_div_t;

  function automatic baud_div_t baud_div(input int unsigned rate);
    baud_div_t d;
    d.div_int  = 16'(B115200_INT);
    d.div_frac = 4'(B115200_FRAC);
    case (rate)
      9600:   begin d.div_int = 16'(B9600_INT);   d.div_frac = 4'(B9600_FRAC);   end
      19200:  begin d.div_int = 16'(B19200_INT);  d.div_frac = 4'(B19200_FRAC);  end
      38400:  begin d.div_int = 16'(B38400_INT);  d.div_frac = 4'(B38400_FRAC);  end
      57600:  begin d.div_int = 16'(B57600_INT);  d.div_frac = 4'(B57600_FRAC);  end
      230400: begin d.div_int = 16'(B230400_INT); d.div_frac = 4'(B230400_FRAC); end
      default: ;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/baudgen_frac_if.sv
// Control and strobe bundle of the fractional baud generator.
interface baudgen_frac_if #(
  parameter int DIV_W  = 16,
  parameter int FRAC_W = 4
);
  logic              clk_ena;
  logic [DIV_W-1:0]  div_int;
  logic [FRAC_W-1:0] div_frac;
  logic              div_load;
  logic              restart;
  logic              tick_ovs;
  logic              clk_out;
  logic              mid_out;

  modport master (
    output clk_ena, div_int, div_frac, div_load, restart,
    input  tick_ovs, clk_out, mid_out
  );

  modport slave (
    input  clk_ena, div_int, div_frac, div_load, restart,
    output tick_ovs, clk_out, mid_out
  );
endinterface

// File: rtl/baudgen_frac_div.sv
// Oversample period generator: integer cycle counter plus optional fractional
// accumulator (BAUDGEN_FRAC_EN). tick_now is the combinational tick event.
module baudgen_frac_div
  import baudgen_frac_pkg::*;
#(
  parameter int DIV_W  = 16,
  parameter int FRAC_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  input  logic [DIV_W-1:0]  div_int_active,
  input  logic [FRAC_W-1:0] div_frac_active,
  input  logic              acc_clr,
  output logic              tick_now,
  output logic              tick_ovs
);

  phase_e            phase_reg;
  logic [DIV_W-1:0]  cnt_reg;
  logic [DIV_W:0]    per_m1_reg;
  logic [DIV_W-1:0]  div_clamped;
  logic [DIV_W:0]    per_m1_next;
  logic              carry;

  always_comb begin
    div_clamped = (div_int_active < DIV_W'(2)) ? DIV_W'(2) : div_int_active;
    // One extra bit so div_int = max with a carry still fits the compare.
    per_m1_next = {1'b0, div_clamped} + {{DIV_W{1'b0}}, carry} - (DIV_W+1)'(1);
  end

`ifdef BAUDGEN_FRAC_EN
  logic [FRAC_W-1:0] acc_reg;
  logic [FRAC_W-1:0] acc_base;
  logic [FRAC_W:0]   acc_sum;

  always_comb begin
    acc_base = acc_clr ? '0 : acc_reg;
    acc_sum  = {1'b0, acc_base} + {1'b0, div_frac_active};
    carry    = acc_sum[FRAC_W];
  end

  always_ff @(posedge clk) begin
    if (rst || !run) begin
      acc_reg <= '0;
    end else if (tick_now) begin
      acc_reg <= acc_sum[FRAC_W-1:0];
    end
  end
`else
  logic unused_frac;
  assign unused_frac = ^{div_frac_active, acc_clr};
  assign carry       = 1'b0;
`endif

  // From idle the counter is treated as already at terminal.
  always_comb begin
    tick_now = run && ((phase_reg == PH_IDLE) || ({1'b0, cnt_reg} == per_m1_reg));
  end

  always_ff @(posedge clk) begin
    if (rst || !run) begin
      phase_reg  <= PH_IDLE;
      cnt_reg    <= '0;
      per_m1_reg <= '0;
      tick_ovs   <= 1'b0;
    end else begin
      tick_ovs <= tick_now;
      if (tick_now) begin
        phase_reg  <= PH_RUN;
        cnt_reg    <= '0;
        per_m1_reg <= per_m1_next;
      end else begin
        cnt_reg <= cnt_reg + DIV_W'(1);
      end
    end
  end

endmodule

// File: rtl/baudgen_frac.sv
// Runtime-programmable fractional baud generator: oversample, bit and mid-bit
// strobes. Define BAUDGEN_FRAC_EN to enable the fractional accumulator.
module baudgen_frac
  import baudgen_frac_pkg::*;
#(
  parameter int DIV_W    = 16,
  parameter int FRAC_W   = 4,
  parameter int OVS      = 16,
  parameter int DEF_INT  = 54,
  parameter int DEF_FRAC = 4
) (
  input  logic           clk,
  input  logic           rst,
  baudgen_frac_if.slave  bus
);

  localparam int OVS_W = $clog2(OVS);
  localparam logic [OVS_W-1:0] LAST_IDX = OVS_W'(OVS - 1);
  localparam logic [OVS_W-1:0] MID_IDX  = OVS_W'(OVS / 2);

  logic [DIV_W-1:0]  act_int_reg;
  logic [FRAC_W-1:0] act_frac_reg;
  logic [DIV_W-1:0]  pend_int_reg;
  logic [FRAC_W-1:0] pend_frac_reg;
  logic              pend_valid_reg;
  logic [OVS_W-1:0]  ovs_idx_reg;
  logic              clk_out_reg;
  logic              mid_out_reg;

  logic              run;
  logic              apply_pend;
  logic [OVS_W-1:0]  idx_next;
  logic [DIV_W-1:0]  sel_int;
  logic [FRAC_W-1:0] sel_frac;
  logic              tick_now;
  logic              tick_ovs_w;

  // A pending divisor takes over exactly at the tick that starts a new bit,
  // so that tick's period already uses it with a cleared accumulator.
  always_comb begin
    run        = bus.clk_ena && !bus.restart;
    idx_next   = ovs_idx_reg + OVS_W'(1);
    apply_pend = pend_valid_reg && (ovs_idx_reg == LAST_IDX);
    sel_int    = apply_pend ? pend_int_reg  : act_int_reg;
    sel_frac   = apply_pend ? pend_frac_reg : act_frac_reg;
  end

  baudgen_frac_div #(
    .DIV_W  (DIV_W),
    .FRAC_W (FRAC_W)
  ) u_div (
    .clk             (clk),
    .rst             (rst),
    .run             (run),
    .div_int_active  (sel_int),
    .div_frac_active (sel_frac),
    .acc_clr         (apply_pend),
    .tick_now        (tick_now),
    .tick_ovs        (tick_ovs_w)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      act_int_reg    <= DIV_W'(DEF_INT);
      act_frac_reg   <= FRAC_W'(DEF_FRAC);
      pend_int_reg   <= '0;
      pend_frac_reg  <= '0;
      pend_valid_reg <= 1'b0;
      ovs_idx_reg    <= LAST_IDX;
      clk_out_reg    <= 1'b0;
      mid_out_reg    <= 1'b0;
    end else if (!run) begin
      ovs_idx_reg    <= LAST_IDX;
      clk_out_reg    <= 1'b0;
      mid_out_reg    <= 1'b0;
      pend_valid_reg <= 1'b0;
      if (bus.div_load) begin
        act_int_reg  <= bus.div_int;
        act_frac_reg <= bus.div_frac;
      end else if (pend_valid_reg) begin
        act_int_reg  <= pend_int_reg;
        act_frac_reg <= pend_frac_reg;
      end
    end else begin
      clk_out_reg <= tick_now && (idx_next == '0);
      mid_out_reg <= tick_now && (idx_next == MID_IDX);
      if (tick_now) begin
        ovs_idx_reg <= idx_next;
      end
      if (tick_now && apply_pend) begin
        act_int_reg    <= pend_int_reg;
        act_frac_reg   <= pend_frac_reg;
        pend_valid_reg <= 1'b0;
      end
      // A load in the boundary cycle itself waits for the following bit.
      if (bus.div_load) begin
        pend_int_reg   <= bus.div_int;
        pend_frac_reg  <= bus.div_frac;
        pend_valid_reg <= 1'b1;
      end
    end
  end

  assign bus.tick_ovs = tick_ovs_w;
  assign bus.clk_out  = clk_out_reg;
  assign bus.mid_out  = mid_out_reg;

endmodule

// File: tb/tb_baudgen_frac.sv
// Self-checking bench for baudgen_frac: per-cycle reference model, directed
// timing sequences, a divisor table and randomized traffic.
module tb_baudgen_frac;
  import baudgen_frac_pkg::*;

  localparam int DIV_W    = 16;
  localparam int FRAC_W   = 4;
  localparam int OVS      = 16;
  localparam int DEF_INT  = 54;
  localparam int DEF_FRAC = 4;

`ifdef BAUDGEN_FRAC_EN
  localparam bit FRAC_ON = 1'b1;
`else
  localparam bit FRAC_ON = 1'b0;
`endif

  localparam int BIT54 = FRAC_ON ? 868 : 864;
  localparam int MID54 = FRAC_ON ? 434 : 432;
  localparam int BIT27 = FRAC_ON ? 434 : 432;
  localparam int MID27 = FRAC_ON ? 217 : 216;

  typedef struct {
    int di;
    int df;
    int bit_f;
    int mid_f;
    int bit_i;
    int mid_i;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  baudgen_frac_if #(.DIV_W(DIV_W), .FRAC_W(FRAC_W)) bus();

  baudgen_frac #(
    .DIV_W    (DIV_W),
    .FRAC_W   (FRAC_W),
    .OVS      (OVS),
    .DEF_INT  (DEF_INT),
    .DEF_FRAC (DEF_FRAC)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Reference model: absolute-time schedule of the next oversample tick.
  int       m_act_int, m_act_frac, m_pend_int, m_pend_frac;
  int       m_idx, m_acc, m_next;
  bit       m_pend_v, m_idle;
  logic [2:0] m_exp;

  function automatic void model_edge(bit r, bit en, bit ld, bit rs, int di, int df);
    int p;
    m_exp = 3'b000;
    if (r) begin
      m_act_int = DEF_INT; m_act_frac = DEF_FRAC;
      m_pend_v = 1'b0; m_idle = 1'b1; m_idx = OVS - 1; m_acc = 0;
    end else if (!en || rs) begin
      if (ld) begin
        m_act_int = di; m_act_frac = df;
      end else if (m_pend_v) begin
        m_act_int = m_pend_int; m_act_frac = m_pend_frac;
      end
      m_pend_v = 1'b0; m_idle = 1'b1; m_idx = OVS - 1; m_acc = 0;
    end else begin
      if (m_idle || cyc == m_next) begin
        m_idx = (m_idx + 1) % OVS;
        m_exp = {1'b1, m_idx == 0, m_idx == OVS / 2};
        if (m_idx == 0 && m_pend_v) begin
          m_act_int = m_pend_int; m_act_frac = m_pend_frac;
          m_pend_v = 1'b0; m_acc = 0;
        end
        p = (m_act_int < 2) ? 2 : m_act_int;
        if (FRAC_ON) begin
          if (m_acc + m_act_frac >= (1 << FRAC_W)) p = p + 1;
          m_acc = (m_acc + m_act_frac) % (1 << FRAC_W);
        end
        m_next = cyc + p;
        m_idle = 1'b0;
      end
      if (ld) begin
        m_pend_int = di; m_pend_frac = df; m_pend_v = 1'b1;
      end
    end
  endfunction

  task automatic step(input bit p_rst, input bit p_ld, input bit p_rs);
    logic [2:0] got;
    rst = p_rst;
    bus.div_load = p_ld;
    bus.restart = p_rs;
    @(posedge clk);
    cyc++;
    model_edge(p_rst, bus.clk_ena, p_ld, p_rs, int'(bus.div_int), int'(bus.div_frac));
    #1;
    got = {bus.tick_ovs, bus.clk_out, bus.mid_out};
    checks++;
    if (got !== m_exp) begin
      errors++;
      $display("FAIL strobes cyc %0d: got tick/clk/mid=%b expected %b", cyc, got, m_exp);
    end
  endtask

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // which: 0 = clk_out, 1 = mid_out, 2 = tick_ovs; t = -1 on timeout.
  task automatic wait_for(input int which, input int limit, output int t);
    t = -1;
    for (int i = 0; i < limit; i++) begin
      step(1'b0, 1'b0, 1'b0);
      if ((which == 0 && bus.clk_out) || (which == 1 && bus.mid_out) ||
          (which == 2 && bus.tick_ovs)) begin
        t = cyc;
        break;
      end
    end
  endtask

  task automatic check_periods(input string tag, input int t_start);
    int tp, tn;
    tp = t_start;
    for (int k = 0; k < 4; k++) begin
      wait_for(2, 100, tn);
      chk($sformatf("%s_period_%0d", tag, k), tn - tp, (FRAC_ON && k == 3) ? 55 : 54);
      tp = tn;
    end
  endtask

  initial begin
    vec_t vecs[6];
    int t0, t1, t2, te, nstrobe;

    vecs[0] = '{54,  4, 868, 434, 864, 432};
    vecs[1] = '{27,  2, 434, 217, 432, 216};
    vecs[2] = '{0,   0,  32,  16,  32,  16};
    vecs[3] = '{1,   5,  37,  18,  32,  16};
    vecs[4] = '{100, 8, 1608, 804, 1600, 800};
    vecs[5] = '{3,  15,  63,  31,  48,  24};

    rst = 1'b1;
    bus.clk_ena = 1'b0; bus.div_int = '0; bus.div_frac = '0;
    bus.div_load = 1'b0; bus.restart = 1'b0;

    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    chk("reset_outputs", int'({bus.tick_ovs, bus.clk_out, bus.mid_out}), 0);

    // First enable from reset with default divisor
    bus.clk_ena = 1'b1; te = cyc;
    wait_for(0, 10, t0);
    chk("enable_latency", t0 - te, 1);
    check_periods("default", t0);
    wait_for(1, 1000, t1); chk("mid_offset_54", t1 - t0, MID54);
    wait_for(0, 1000, t2); chk("bit_54", t2 - t0, BIT54);

    // Drop clk_ena mid-bit for 100 cycles
    repeat (300) step(1'b0, 1'b0, 1'b0);
    bus.clk_ena = 1'b0; nstrobe = 0;
    for (int i = 0; i < 100; i++) begin
      step(1'b0, 1'b0, 1'b0);
      if (bus.tick_ovs || bus.clk_out || bus.mid_out) nstrobe++;
    end
    chk("strobes_while_disabled", nstrobe, 0);
    bus.clk_ena = 1'b1; te = cyc;
    wait_for(0, 10, t0);
    chk("reenable_latency", t0 - te, 1);
    check_periods("reenable", t0);

    // Load 27/2 in the middle of a running bit
    wait_for(0, 1000, t0);
    repeat (200) step(1'b0, 1'b0, 1'b0);
    bus.div_int = 16'd27; bus.div_frac = 4'd2;
    step(1'b0, 1'b1, 1'b0);
    wait_for(0, 1000, t1); chk("bit_before_load", t1 - t0, BIT54);
    wait_for(2, 100, t2);  chk("first_period_27", t2 - t1, 27);
    wait_for(1, 1000, t2); chk("mid_27", t2 - t1, MID27);
    wait_for(0, 1000, t2); chk("bit_27", t2 - t1, BIT27);

    // Restart 200 cycles into a bit
    repeat (200) step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1); te = cyc;
    wait_for(0, 10, t0);   chk("restart_latency", t0 - te, 1);
    wait_for(1, 1000, t1); chk("restart_mid", t1 - t0, MID27);

    // Restart together with a divisor load
    repeat (100) step(1'b0, 1'b0, 1'b0);
    bus.div_int = 16'd54; bus.div_frac = 4'd4;
    step(1'b0, 1'b1, 1'b1); te = cyc;
    wait_for(0, 10, t0);   chk("restart_load_latency", t0 - te, 1);
    wait_for(0, 2000, t1); chk("restart_load_bit", t1 - t0, BIT54);

    // Reset beats restart; a pending load is discarded
    bus.div_int = 16'd27; bus.div_frac = 4'd2;
    step(1'b0, 1'b1, 1'b0);
    repeat (150) step(1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1);
    chk("rst_wins_outputs", int'({bus.tick_ovs, bus.clk_out, bus.mid_out}), 0);
    te = cyc;
    wait_for(0, 10, t0);   chk("rst_restart_latency", t0 - te, 1);
    wait_for(0, 2000, t1); chk("rst_defaults_bit", t1 - t0, BIT54);

    // Divisor table, loaded while idle
    for (int v = 0; v < 6; v++) begin
      bus.clk_ena = 1'b0;
      step(1'b0, 1'b0, 1'b0);
      bus.div_int = DIV_W'(vecs[v].di); bus.div_frac = FRAC_W'(vecs[v].df);
      step(1'b0, 1'b1, 1'b0);
      bus.clk_ena = 1'b1;
      wait_for(0, 10, t0);
      wait_for(1, 4000, t1);
      wait_for(0, 4000, t2);
      chk($sformatf("vec%0d_mid", v), t1 - t0, FRAC_ON ? vecs[v].mid_f : vecs[v].mid_i);
      chk($sformatf("vec%0d_bit", v), t2 - t0, FRAC_ON ? vecs[v].bit_f : vecs[v].bit_i);
    end

    // Randomized traffic against the model
    bus.clk_ena = 1'b1;
    for (int i = 0; i < 12000; i++) begin
      int r;
      bit ld, rs, rr;
      r = $urandom_range(0, 999);
      ld = 1'b0; rs = 1'b0; rr = (r == 999);
      if (r < 4) begin
        bus.clk_ena = ~bus.clk_ena;
      end else if (r < 12) begin
        bus.div_int  = DIV_W'(($urandom_range(0, 9) == 0) ? $urandom_range(0, 80) : $urandom_range(0, 12));
        bus.div_frac = FRAC_W'($urandom);
        ld = 1'b1;
      end else if (r < 15) begin
        rs = 1'b1;
      end
      step(rr, ld, rs);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/baudgen_frac.md
Name: baudgen_frac

Overview:
- Runtime-programmable, fractional-divide baud generator. Successor to the fixed-divisor UART baud generator.
- Produces three single-cycle strobes for the UART TX/RX paths:
  - an oversample tick (OVS per bit),
  - a bit tick (clk_out),
  - a mid-bit tick (mid_out) for RX sampling.
- Divisor is reloadable at run time without glitches; phase can be re-aligned on an RX start-bit edge.

Parameters:
- DIV_W, 16, width of the integer divisor (clock cycles per oversample tick).
- FRAC_W, 4, width of the fractional divisor (units of 1/2^FRAC_W cycle).
- OVS, 16, oversample ticks per bit. Power of two, >= 4.
- DEF_INT, 54, integer divisor loaded at reset (115200 baud x16 at 100 MHz).
- DEF_FRAC, 4, fractional divisor loaded at reset (54 + 4/16 = 54.25).

Ports:
- clk  in  1  system clock, 100 MHz.
- rst  in  1  synchronous, active-high reset.
- clk_ena  in  1  1 = run; 0 = hold in idle phase, no strobes.
- div_int  in  DIV_W  new integer divisor.
- div_frac  in  FRAC_W  new fractional divisor.
- div_load  in  1  one-cycle strobe; captures div_int/div_frac.
- restart  in  1  one-cycle strobe; re-phases the generator (RX start-bit alignment).
- tick_ovs  out  1  oversample strobe, registered.
- clk_out  out  1  bit strobe, registered.
- mid_out  out  1  mid-bit strobe, registered.

Behaviour:
- **Reset.** Reset is synchronous and active-high. On rst:
  - all outputs 0;
  - active divisor = DEF_INT/DEF_FRAC;
  - no pending load;
  - idle phase: cycle counter at terminal, ovs_idx = OVS-1, acc = 0.
- **Priority.** rst > clk_ena=0 > restart > normal count.
- **Idle phase.** clk_ena=0 or restart forces the idle phase (as on reset, divisor kept) and clears all outputs the next cycle.
- **Enable latency.** The first edge sampling clk_ena=1 from idle asserts tick_ovs and clk_out in the following cycle (1-cycle latency). ovs_idx becomes 0 at that edge.
- **Period length.** Each oversample period lasts P cycles:
  - P = div_int_active + c;
  - c = carry out of acc + div_frac_active, computed at the tick that starts the period;
  - acc wraps modulo 2^FRAC_W.
- **Tick decoding.** Each tick_ovs increments ovs_idx modulo OVS.
  - clk_out fires with tick_ovs when ovs_idx becomes 0.
  - mid_out fires with tick_ovs when ovs_idx becomes OVS/2.
  - All strobes are exactly 1 cycle wide and never asserted while clk_ena=0.
- **Divisor loading.**
  - When running: div_load captures into a pending register; it is applied at the next bit boundary (the clk_out tick), and acc clears then. The current bit is never distorted.
  - When idle: div_load applies immediately.
  - A second div_load before application overwrites the pending value.
- **Clamping.** div_int < 2 is clamped to 2, giving a minimum oversample period of 2 cycles.
- **restart while running.** Re-phases the generator: clk_out fires 1 cycle after the restart edge, then mid_out OVS/2 ticks later.
- **restart + div_load same cycle.** The new divisor takes effect for the re-phased bit.
- **Counter widths.** The cycle counter is DIV_W bits and compares against div_int_active + c - 1. It must not overflow at div_int = 2^DIV_W-1 with c = 1 (use a DIV_W+1 bit compare).

Optional Feature:
- Macro BAUDGEN_FRAC_EN.
- Defined: fractional accumulator present, behaviour as above.
- Undefined: no accumulator; div_frac is ignored; c is always 0; P = div_int_active. The div_frac port is kept but unused, for a uniform interface.

Decomposition:
- Shared header baudgen.vh holds:
  - x16 divisor constants per standard baud rate at 100 MHz, integer and fraction;
  - existing B-rate names with suffixes _INT/_FRAC.
- Sub-module baudgen_frac_div: clk, rst, run, div_int_active, div_frac_active, period counter, accumulator, produces tick_ovs.
- Top level holds ovs_idx, load/restart control and strobe decode.

Test Plan:
- Reset then clk_ena=1 at edge E0, default 54/4:
  - tick_ovs+clk_out in cycle E0+1;
  - tick periods repeat 54,54,54,55;
  - clk_out spacing 868 cycles;
  - mid_out 434 cycles after each clk_out.
- clk_ena dropped mid-bit, raised 100 cycles later:
  - no strobes while low;
  - clk_out exactly 1 cycle after re-enable;
  - pattern restarts 54,54,54,55.
- While running, div_load 27/2 mid-bit:
  - current bit still 868 cycles;
  - from the next clk_out, periods follow 27,27,27,27,27,27,27,28 (acc carries every 8th tick);
  - 434 cycles per bit.
- div_load with div_int=0 or 1 -> tick_ovs every 2 cycles; clk_out every 32 cycles (div_frac=0).
- restart pulse 200 cycles into a bit -> clk_out at restart+1, mid_out 8 ticks later. With simultaneous rst, rst wins: all outputs 0 and defaults reloaded.
- Build without BAUDGEN_FRAC_EN, div 54/4 -> every tick period exactly 54; clk_out spacing 864.
